// File: rtl/button_event_unit_pkg.sv
// Shared event-type codes, channel state encoding and parameter helpers
// for the button event unit.
package button_event_unit_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'b00;
  localparam logic [1:0] EVT_RELEASE = 2'b01;
  localparam logic [1:0] EVT_LONG    = 2'b10;
  localparam logic [1:0] EVT_REPEAT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESSED = 2'b01,
    HELD    = 2'b10
  } chan_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_channel.sv
// Per-button press/release/long/repeat FSM with a one-deep pending event slot.
// Auto-repeat in HELD is built only when BUTTON_EVENT_AUTO_REPEAT_EN is defined.
module button_event_channel
  import button_event_unit_pkg::*;
#(
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 20_000_000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       level,
  input  logic       drain,
  output logic       pend_valid,
  output logic [1:0] pend_type,
  output logic       held,
  output logic       drop
);

  localparam int CNT_W = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES));
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  chan_state_t      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             prev_r;
  logic             pend_valid_r;
  logic [1:0]       pend_type_r;
  logic             held_r;
  logic             evt_s;
  logic [1:0]       evt_type_s;

  // Event decode; release is checked first so it beats LONG/REPEAT
  always_comb begin
    evt_s      = 1'b0;
    evt_type_s = EVT_PRESS;
    case (state_r)
      IDLE: begin
        if (level && !prev_r) begin
          evt_s      = 1'b1;
          evt_type_s = EVT_PRESS;
        end else begin
          evt_s = 1'b0;
        end
      end
      PRESSED: begin
        if (!level) begin
          evt_s      = 1'b1;
          evt_type_s = EVT_RELEASE;
        end else if (cnt_r == LONG_LAST) begin
          evt_s      = 1'b1;
          evt_type_s = EVT_LONG;
        end else begin
          evt_s = 1'b0;
        end
      end
      HELD: begin
        if (!level) begin
          evt_s      = 1'b1;
          evt_type_s = EVT_RELEASE;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
        end else if (cnt_r == REPEAT_LAST) begin
          evt_s      = 1'b1;
          evt_type_s = EVT_REPEAT;
`endif
        end else begin
          evt_s = 1'b0;
        end
      end
      default: evt_s = 1'b0;
    endcase
  end

  assign drop = evt_s & pend_valid_r & ~drain;

  // Channel FSM, counter, held flag and pending slot
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      prev_r       <= 1'b0;
      pend_valid_r <= 1'b0;
      pend_type_r  <= EVT_PRESS;
      held_r       <= 1'b0;
    end else begin
      prev_r <= level;
      case (state_r)
        IDLE: begin
          held_r <= 1'b0;
          if (level && !prev_r) begin
            state_r <= PRESSED;
            cnt_r   <= '0;
          end
        end
        PRESSED: begin
          if (!level) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else if (cnt_r == LONG_LAST) begin
            state_r <= HELD;
            held_r  <= 1'b1;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        HELD: begin
          if (!level) begin
            state_r <= IDLE;
            held_r  <= 1'b0;
            cnt_r   <= '0;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
          end else if (cnt_r == REPEAT_LAST) begin
            cnt_r <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
`else
          end else begin
            cnt_r <= '0;
          end
`endif
        end
        default: begin
          state_r <= IDLE;
          held_r  <= 1'b0;
          cnt_r   <= '0;
        end
      endcase

      // a drain in this cycle frees the slot for a simultaneous new event
      if (evt_s && (!pend_valid_r || drain)) begin
        pend_valid_r <= 1'b1;
        pend_type_r  <= evt_type_s;
      end else if (drain) begin
        pend_valid_r <= 1'b0;
      end
    end
  end

  assign pend_valid = pend_valid_r;
  assign pend_type  = pend_type_r;
  assign held       = held_r;

endmodule

// File: rtl/button_event_unit.sv
// Four button channels feeding a fixed-priority arbiter and show-ahead event FIFO.
// Optional macro BUTTON_EVENT_AUTO_REPEAT_EN enables REPEAT events while held.
module button_event_unit
  import button_event_unit_pkg::*;
#(
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 20_000_000,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic [3:0]                    button_in_debounced,
  output logic                          event_valid,
  output logic [3:0]                    event_code,
  input  logic                          event_ready,
  output logic [$clog2(FIFO_DEPTH):0]   event_count,
  output logic [3:0]                    button_held,
  output logic                          overflow,
  input  logic                          overflow_clear
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    pend_valid_s;
  logic [1:0]    pend_type_s [4];
  logic [3:0]    held_s;
  logic [3:0]    drop_s;
  logic [3:0]    grant_s;
  logic [1:0]    win_idx_s;
  logic          any_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] count_nxt_s;

  logic [3:0]    fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          valid_r;
  logic          overflow_r;

  for (genvar i = 0; i < 4; i++) begin : g_chan
    button_event_channel #(
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_chan (
      .clk_in    (clk_in),
      .reset     (reset),
      .level     (button_in_debounced[i]),
      .drain     (grant_s[i]),
      .pend_valid(pend_valid_s[i]),
      .pend_type (pend_type_s[i]),
      .held      (held_s[i]),
      .drop      (drop_s[i])
    );
  end

  // Lowest-index pending channel wins; a full FIFO accepts only alongside a pop
  always_comb begin
    any_s     = 1'b1;
    win_idx_s = 2'd0;
    casez (pend_valid_s)
      4'b???1: win_idx_s = 2'd0;
      4'b??10: win_idx_s = 2'd1;
      4'b?100: win_idx_s = 2'd2;
      4'b1000: win_idx_s = 2'd3;
      default: any_s     = 1'b0;
    endcase
    pop_s   = valid_r & event_ready;
    push_s  = any_s & ((count_r != CW'(FIFO_DEPTH)) | pop_s);
    grant_s = push_s ? (4'b0001 << win_idx_s) : 4'b0000;
  end

  // Occupancy next-state
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage, written without reset since occupancy guards reads
  always_ff @(posedge clk_in) begin
    if (push_s && !reset) begin
      fifo_mem_r[wr_ptr_r] <= {pend_type_s[win_idx_s], win_idx_s};
    end
  end

  // FIFO pointers, occupancy and valid flag
  always_ff @(posedge clk_in) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != CW'(0));
    end
  end

  // Sticky overflow; a drop in the same cycle beats the clear
  always_ff @(posedge clk_in) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (|drop_s) begin
      overflow_r <= 1'b1;
    end else if (overflow_clear) begin
      overflow_r <= 1'b0;
    end
  end

  assign event_valid = valid_r;
  assign event_code  = fifo_mem_r[rd_ptr_r];
  assign event_count = count_r;
  assign button_held = held_s;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_button_event_unit.sv
// Scoreboard bench for button_event_unit: expected codes are queued as stimulus
// is applied and checked as the consumer pops events.
module tb_button_event_unit;

  localparam int LONG  = 10;
  localparam int REP   = 4;
  localparam int DEPTH = 8;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic       event_ready = 1'b0;
  logic       overflow_clear = 1'b0;
  logic       event_valid;
  logic [3:0] event_code;
  logic [3:0] event_count;
  logic [3:0] button_held;
  logic       overflow;

  int         cmp_count = 0;
  int         err_count = 0;
  int         cyc = 0;
  logic [3:0] exp_q [$];
  int         obs_t [$];

  button_event_unit #(
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(REP),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_in             (clk_in),
    .reset              (reset),
    .button_in_debounced(btn),
    .event_valid        (event_valid),
    .event_code         (event_code),
    .event_ready        (event_ready),
    .event_count        (event_count),
    .button_held        (button_held),
    .overflow           (overflow),
    .overflow_clear     (overflow_clear)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Scoreboard: compare each event the consumer is about to accept
  always @(negedge clk_in) begin
    if (!reset && event_valid && event_ready) begin
      cmp_count++;
      if (exp_q.size() == 0) begin
        err_count++;
        $display("FAIL unexpected_event: got code %0h, expected no event", event_code);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (event_code !== e) begin
          err_count++;
          $display("FAIL event_code: got %0h expected %0h", event_code, e);
        end
      end
      obs_t.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    cmp_count++;
    if (exp_q.size() != 0) begin
      err_count++;
      $display("FAIL drain_timeout: %0d events outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
    cmp_count++;
    if (event_count !== 4'd0) begin
      err_count++;
      $display("FAIL idle_count: got %0d expected 0", event_count);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    cmp_count += 4;
    if (event_valid !== 1'b0) begin err_count++; $display("FAIL rst_valid: got %b expected 0", event_valid); end
    if (event_count !== 4'd0) begin err_count++; $display("FAIL rst_count: got %0d expected 0", event_count); end
    if (button_held !== 4'b0) begin err_count++; $display("FAIL rst_held: got %b expected 0000", button_held); end
    if (overflow !== 1'b0) begin err_count++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
    reset = 1'b0;
    event_ready = 1'b1;
    tick();
    tick();
    cmp_count += 2;
    if (event_valid !== 1'b0) begin err_count++; $display("FAIL post_rst_valid: got %b expected 0", event_valid); end
    if (event_count !== 4'd0) begin err_count++; $display("FAIL post_rst_count: got %0d expected 0", event_count); end
  endtask

  // Hold one button for ncyc cycles; covers short press, release-beats-LONG and repeats
  task automatic test_hold(input int idx, input int ncyc);
    logic [1:0] ix;
    logic [3:0] hb;
    bit         has_long;
    int         n_rep;
    int         n_exp;
    ix = idx[1:0];
    hb = 4'b0001 << idx;
    obs_t.delete();
    has_long = (ncyc >= LONG + 1);
    n_rep = (has_long && REP_EN) ? (ncyc - 1 - LONG) / REP : 0;
    exp_q.push_back({2'b00, ix});
    if (has_long) exp_q.push_back({2'b10, ix});
    for (int r = 0; r < n_rep; r++) exp_q.push_back({2'b11, ix});
    exp_q.push_back({2'b01, ix});
    btn[idx] = 1'b1;
    for (int i = 1; i <= ncyc; i++) begin
      tick();
      if (i == LONG / 2) begin
        cmp_count++;
        if (button_held !== 4'b0) begin err_count++; $display("FAIL held_early: got %b expected 0000", button_held); end
      end
      if (has_long && i == LONG + 1) begin
        cmp_count++;
        if (button_held !== hb) begin err_count++; $display("FAIL held_long: got %b expected %b", button_held, hb); end
      end
    end
    btn[idx] = 1'b0;
    tick();
    tick();
    cmp_count++;
    if (button_held !== 4'b0) begin err_count++; $display("FAIL held_release: got %b expected 0000", button_held); end
    wait_drain();
    n_exp = 2 + (has_long ? 1 : 0) + n_rep;
    cmp_count++;
    if (obs_t.size() != n_exp) begin
      err_count++;
      $display("FAIL hold_event_total: got %0d expected %0d", obs_t.size(), n_exp);
    end else begin
      cmp_count++;
      if (obs_t[n_exp-1] - obs_t[0] != ncyc) begin
        err_count++;
        $display("FAIL release_spacing: got %0d expected %0d", obs_t[n_exp-1] - obs_t[0], ncyc);
      end
      if (has_long) begin
        cmp_count++;
        if (obs_t[1] - obs_t[0] != LONG) begin
          err_count++;
          $display("FAIL long_spacing: got %0d expected %0d", obs_t[1] - obs_t[0], LONG);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    obs_t.delete();
    exp_q.push_back(4'h1);
    exp_q.push_back(4'h3);
    btn = 4'b1010;
    tick();
    tick();
    wait_drain();
    cmp_count++;
    if (obs_t.size() != 2 || obs_t[1] - obs_t[0] != 1) begin
      err_count++;
      $display("FAIL simul_spacing: got %0d events, expected 2 one cycle apart", obs_t.size());
    end
    exp_q.push_back(4'h5);
    exp_q.push_back(4'h7);
    btn = 4'b0000;
    wait_drain();
  endtask

  task automatic test_backpressure();
    event_ready = 1'b0;
    for (int j = 0; j < 9; j++) exp_q.push_back((j % 2 == 0) ? 4'h0 : 4'h4);
    for (int t = 0; t < 6; t++) begin
      btn[0] = 1'b1;
      tick();
      tick();
      btn[0] = 1'b0;
      tick();
      tick();
    end
    tick();
    tick();
    cmp_count += 3;
    if (event_count !== 4'(DEPTH)) begin err_count++; $display("FAIL full_count: got %0d expected %0d", event_count, DEPTH); end
    if (overflow !== 1'b1) begin err_count++; $display("FAIL overflow_set: got %b expected 1", overflow); end
    if (event_valid !== 1'b1) begin err_count++; $display("FAIL full_valid: got %b expected 1", event_valid); end
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    cmp_count++;
    if (overflow !== 1'b0) begin err_count++; $display("FAIL overflow_clear: got %b expected 0", overflow); end
    event_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    event_ready = 1'b0;
    btn = 4'b0011;
    tick();
    tick();
    btn = 4'b0010;
    repeat (3) tick();
    cmp_count++;
    if (event_count !== 4'd3) begin err_count++; $display("FAIL pre_reset_count: got %0d expected 3", event_count); end
    reset = 1'b1;
    tick();
    tick();
    cmp_count += 3;
    if (event_count !== 4'd0) begin err_count++; $display("FAIL mid_reset_count: got %0d expected 0", event_count); end
    if (event_valid !== 1'b0) begin err_count++; $display("FAIL mid_reset_valid: got %b expected 0", event_valid); end
    if (overflow !== 1'b0) begin err_count++; $display("FAIL mid_reset_overflow: got %b expected 0", overflow); end
    exp_q.push_back(4'h1);
    reset = 1'b0;
    event_ready = 1'b1;
    wait_drain();
    exp_q.push_back(4'h5);
    btn = 4'b0000;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_hold(0, 5);
    test_hold(0, LONG);
    test_hold(0, LONG + 1);
    test_hold(2, 25);
    test_hold(0, 30);
    test_simultaneous();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
